psec6_spi_ctrl: RTL and testbench
=================================

Name: psec6_spi_ctrl

Overview:
- On-board SPI controller (initiator) that drives the psec6_spi peripheral: it generates cs, spi_clk and pico, and samples poci_spi.
- Accepts one register transaction at a time (write or read of a 7-bit address) from host-side logic or an FPGA sequencer.
- Serialises each transaction as a 16-bit frame: command byte {rw, addr[6:0]}, then data byte, MSB first. cs is active-high.
- Returns read data, plus an error flag for a nonzero poci during the command byte.

Parameters:
- CLK_DIV, 2, spi_clk half-period in clk cycles; must be ≥1.
- CS_GAP, 4, minimum clk cycles cs stays low between frames.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  transaction request
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_rw  in  1  1 = write, 0 = read
- req_addr  in  7  register address
- req_wdata  in  8  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse at transaction end
- rsp_rdata  out  8  data-byte bits shifted in from poci; held until next rsp_valid
- rsp_addr_err  out  1  any poci=1 sampled during command byte; held with rsp_rdata
- rsp_verify_err  out  1  readback mismatch (0 unless PSEC6_SPI_CTRL_VERIFY_EN)
- cs  out  1  chip select, active-high
- spi_clk  out  1  SPI clock, idles low
- pico  out  1  controller-out data
- poci  in  1  peripheral-out data

Behaviour:
- Reset (async assert, clocked deassert) values: state=IDLE, cs=0, spi_clk=0, pico=0, rsp_valid=0, rsp_rdata=0, rsp_addr_err=0, rsp_verify_err=0. req_ready=1 from the first cycle after reset.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: on accept, latch frame={req_rw,req_addr,req_wdata} and go to SETUP.
- SETUP: cs=1, spi_clk=0, pico=frame[15]. Lasts one half-period (CLK_DIV cycles).
- SHIFT: 16 bits, each one full spi_clk period.
  - spi_clk rises at the start of the high half and falls at the start of the low half.
  - pico changes only on falling edges, to the next frame bit; after the 16th fall it holds frame[0].
  - poci is sampled in the clk cycle of each falling edge: sample k (k=1..16) follows rising edge k.
  - Samples 1..8 are OR-reduced into addr_err.
  - Samples 9..16 shift in MSB-first as rdata = {rdata[6:0], poci}.
- HOLD: spi_clk=0, cs=1 for one half-period. Then cs=0; in that same cycle rsp_valid=1 and rsp_* are updated.
- GAP: cs=0 for CS_GAP cycles with req_ready=0, then IDLE.
- Frame timing: cs high for exactly 34*CLK_DIV cycles. Minimum request-to-request spacing is 34*CLK_DIV+CS_GAP+1 cycles.
- Half-period counter: width $clog2(CLK_DIV+1); it resets to 0 at every state change. The bit counter is 5 bits, counting 0..15.
- Boundary rules:
  - req_valid while not ready is ignored; no queuing.
  - Request fields are sampled only at accept; later changes have no effect.
  - rst mid-frame: cs, spi_clk and pico drop to 0 immediately and asynchronously, with no rsp_valid. The next frame restarts from SETUP.
  - For writes, rsp_rdata still reflects the sampled poci bits.

Optional Feature:
- Macro: PSEC6_SPI_CTRL_VERIFY_EN.
- Defined: after a write frame's GAP, the controller automatically issues a read frame to the same address, with req_ready held 0 throughout.
  - rsp_valid pulses once, at the end of the readback frame.
  - rsp_rdata carries the readback data.
  - rsp_verify_err = (readback != written data).
  - rsp_addr_err = OR of both frames' errors.
  - Reads are unaffected.
- Undefined: single frame per request; rsp_verify_err is tied to 0.

Decomposition:
- psec6_spi_pkg holds:
  - address constants: ADDR_VCO_BAND=1, ADDR_TRIG_MASK=2, ADDR_INST=3, ADDR_MODE=4, ADDR_DISC_POL=5, ADDR_REFCLK_SEL=6, ADDR_SLOW_MODE=7, ADDR_TRIG_DELAY=8, ADDR_PLL_SWITCH=9
  - instruction codes: INST_RST=1, INST_READOUT=2, INST_START=3
  - typedef spi_frame_t: packed struct of rw, addr[6:0], data[7:0]
  - enum ctrl_state_t
- One sub-module, psec6_spi_ctrl_tick: the half-period counter, emitting a one-cycle tick every CLK_DIV cycles while enabled and clearing when disabled.

Test Plan:
- Write addr 1 data 0xFF, CLK_DIV=2, psec6_spi attached → pico bits 0x81 then 0xFF; cs high 68 cycles; vco_digital_band=6'h3F; rsp_addr_err=0.
- Write addr 3 data 3 → peripheral clk_enable=1 after cs falls; rsp_valid is a single pulse.
- Read addr 1 after that write → pico 0x01,0x00; rsp_rdata=0xFF (peripheral's full register byte); rsp_addr_err=0.
- Behavioural peripheral drives poci=1 during command byte → rsp_addr_err=1.
- req_valid held high for 2 requests → second accepted no earlier than 68+4+1 cycles after first; cs low ≥4 cycles between frames.
- rst pulse during bit 10 → cs, spi_clk and pico become 0 in the same cycle; no rsp_valid; next request completes normally.
- (VERIFY_EN) write with a model that corrupts bit0 on readback → one rsp_valid, rsp_verify_err=1.

Source files
------------

// File: rtl/psec6_spi_pkg.sv
// Shared types and register map for the psec6 SPI controller.
package psec6_spi_pkg;

  localparam logic [6:0] ADDR_VCO_BAND   = 7'd1;
  localparam logic [6:0] ADDR_TRIG_MASK  = 7'd2;
  localparam logic [6:0] ADDR_INST       = 7'd3;
  localparam logic [6:0] ADDR_MODE       = 7'd4;
  localparam logic [6:0] ADDR_DISC_POL   = 7'd5;
  localparam logic [6:0] ADDR_REFCLK_SEL = 7'd6;
  localparam logic [6:0] ADDR_SLOW_MODE  = 7'd7;
  localparam logic [6:0] ADDR_TRIG_DELAY = 7'd8;
  localparam logic [6:0] ADDR_PLL_SWITCH = 7'd9;

  localparam logic [7:0] INST_RST     = 8'd1;
  localparam logic [7:0] INST_READOUT = 8'd2;
  localparam logic [7:0] INST_START   = 8'd3;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } spi_frame_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } ctrl_state_t;

endpackage

// File: rtl/psec6_spi_ctrl_tick.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles while enabled, cleared when disabled.
module psec6_spi_ctrl_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt_q <= '0;
    else if (!en_i || tick_o) cnt_q <= '0;
    else                      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/psec6_spi_ctrl.sv
// SPI initiator for psec6_spi: 16-bit {rw,addr,data} frames, cs active-high, mode 0.
// Define PSEC6_SPI_CTRL_VERIFY_EN to follow every write with an automatic readback frame.
module psec6_spi_ctrl
  import psec6_spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_addr_err,
  output logic       rsp_verify_err,
  output logic       cs,
  output logic       spi_clk,
  output logic       pico,
  input  logic       poci
);

  localparam int GW = $clog2(CS_GAP + 1);

  ctrl_state_t   state_q;
  spi_frame_t    frame_q;
  logic [15:0]   fbits;
  logic [4:0]    bit_q;
  logic [GW-1:0] gap_q;
  logic [7:0]    sh_q;
  logic          err_acc_q;
  logic          tick;

  assign fbits     = frame_q;
  assign req_ready = (state_q == ST_IDLE);

  psec6_spi_ctrl_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q inside {ST_SETUP, ST_SHIFT, ST_HOLD}),
    .tick_o (tick)
  );

`ifdef PSEC6_SPI_CTRL_VERIFY_EN
  logic       vfy_q;
  logic [7:0] wd_q;
  logic       verify_err_q;
  assign rsp_verify_err = verify_err_q;
`else
  assign rsp_verify_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_q      <= '0;
      bit_q        <= '0;
      gap_q        <= '0;
      sh_q         <= '0;
      err_acc_q    <= 1'b0;
      cs           <= 1'b0;
      spi_clk      <= 1'b0;
      pico         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_addr_err <= 1'b0;
`ifdef PSEC6_SPI_CTRL_VERIFY_EN
      vfy_q        <= 1'b0;
      wd_q         <= '0;
      verify_err_q <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state_q)
        ST_IDLE: if (req_valid) begin
          frame_q   <= '{rw: req_rw, addr: req_addr, data: (req_rw ? req_wdata : 8'h00)};
          state_q   <= ST_SETUP;
          cs        <= 1'b1;
          pico      <= req_rw;
          bit_q     <= '0;
          sh_q      <= '0;
          err_acc_q <= 1'b0;
`ifdef PSEC6_SPI_CTRL_VERIFY_EN
          vfy_q     <= 1'b0;
`endif
        end
        ST_SETUP: if (tick) begin
          state_q <= ST_SHIFT;
          spi_clk <= 1'b1;
        end
        ST_SHIFT: if (tick) begin
          // High half ends: fall, sample poci, advance pico. Low half ends: rise or finish.
          if (spi_clk) begin
            spi_clk <= 1'b0;
            if (bit_q < 5'd8) err_acc_q <= err_acc_q | poci;
            else              sh_q      <= {sh_q[6:0], poci};
            if (bit_q != 5'd15) pico <= fbits[4'd14 - bit_q[3:0]];
          end else if (bit_q == 5'd15) begin
            state_q <= ST_HOLD;
          end else begin
            bit_q   <= bit_q + 5'd1;
            spi_clk <= 1'b1;
          end
        end
        ST_HOLD: if (tick) begin
          cs      <= 1'b0;
          state_q <= ST_GAP;
          gap_q   <= '0;
`ifdef PSEC6_SPI_CTRL_VERIFY_EN
          if (frame_q.rw && !vfy_q) begin
            vfy_q <= 1'b1;
            wd_q  <= frame_q.data;
          end else begin
            rsp_valid    <= 1'b1;
            rsp_rdata    <= sh_q;
            rsp_addr_err <= err_acc_q;
            verify_err_q <= vfy_q && (sh_q != wd_q);
          end
`else
          rsp_valid    <= 1'b1;
          rsp_rdata    <= sh_q;
          rsp_addr_err <= err_acc_q;
`endif
        end
        ST_GAP: begin
          if (gap_q == GW'(CS_GAP - 1)) begin
            state_q <= ST_IDLE;
`ifdef PSEC6_SPI_CTRL_VERIFY_EN
            // Write just finished: read the same address back; err_acc_q keeps accumulating.
            if (vfy_q && frame_q.rw) begin
              frame_q <= '{rw: 1'b0, addr: frame_q.addr, data: 8'h00};
              state_q <= ST_SETUP;
              cs      <= 1'b1;
              pico    <= 1'b0;
              bit_q   <= '0;
              sh_q    <= '0;
            end
`endif
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psec6_spi_ctrl.sv
// Scoreboard bench for psec6_spi_ctrl with a behavioural psec6_spi peripheral model.
module tb_psec6_spi_ctrl;
  import psec6_spi_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 4;
  localparam int FRAME   = 34 * CLK_DIV;

  logic       clk = 0, rst = 0;
  logic       req_valid = 0, req_rw = 0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, rsp_addr_err, rsp_verify_err;
  logic [7:0] rsp_rdata;
  logic       cs, spi_clk, pico;
  logic       poci = 0;

  typedef struct packed {
    logic [7:0] rdata;
    logic       addr_err;
    logic       verify_err;
  } exp_t;

  int   n_chk = 0, n_fail = 0;
  int   rsp_cnt = 0;
  int   cyc = 0;
  bit   prev_vld = 0;
  exp_t exp_q[$];

  psec6_spi_ctrl #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_addr_err(rsp_addr_err),
    .rsp_verify_err(rsp_verify_err),
    .cs(cs), .spi_clk(spi_clk), .pico(pico), .poci(poci)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- peripheral model ----------------
  logic [7:0]  regs [0:127];
  logic [15:0] sh = '0;
  logic [7:0]  rd = '0;
  int          bcnt = 0;
  bit          err_mode = 0, corrupt = 0;
  logic [15:0] frames[$];

  initial for (int i = 0; i < 128; i++) regs[i] = 8'h00;

  always @(posedge cs) begin
    bcnt = 0;
    poci = err_mode;
  end

  always @(posedge spi_clk) if (cs) begin
    sh = {sh[14:0], pico};
    bcnt++;
    if (bcnt == 16) begin
      frames.push_back(sh);
      if (sh[15]) regs[sh[14:8]] = sh[7:0];
    end
  end

  always @(negedge spi_clk) if (cs) begin
    if (bcnt == 8) begin
      rd   = sh[7] ? 8'h00 : (regs[sh[6:0]] ^ {7'h0, corrupt});
      poci = rd[7];
    end else if (bcnt > 8 && bcnt < 16) begin
      poci = rd[15-bcnt];
    end else if (bcnt >= 16) begin
      poci = 1'b0;
    end
  end

  // ---------------- cs run-length monitor ----------------
  int hi_run = 0, lo_run = 0, last_hi = 0, last_lo = 0;
  always @(negedge clk) begin
    if (cs) begin
      hi_run++;
      if (lo_run > 0) begin last_lo = lo_run; lo_run = 0; end
    end else begin
      lo_run++;
      if (hi_run > 0) begin last_hi = hi_run; hi_run = 0; end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  exp_t e_mon;
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cnt++;
      check("rsp_single_pulse", 32'(prev_vld), 32'd0);
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid with rdata %0h, expected none", rsp_rdata);
      end else begin
        e_mon = exp_q.pop_front();
        check("rsp_rdata",      32'(rsp_rdata),      32'(e_mon.rdata));
        check("rsp_addr_err",   32'(rsp_addr_err),   32'(e_mon.addr_err));
        check("rsp_verify_err", 32'(rsp_verify_err), 32'(e_mon.verify_err));
      end
    end
    prev_vld = rsp_valid;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [7:0] exp_wr(input logic [7:0] d);
`ifdef PSEC6_SPI_CTRL_VERIFY_EN
    return d;
`else
    return 8'h00;
`endif
  endfunction

  task automatic wait_ready(output int acc);
    int t = 0;
    while (!req_ready && t < 500) begin @(negedge clk); t++; end
    if (!req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL req_ready_timeout: got ready 0 expected 1");
    end
    acc = cyc;
  endtask

  task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] d,
                       input bit push, input exp_t e);
    int ac;
    @(negedge clk);
    req_valid = 1; req_rw = rw; req_addr = a; req_wdata = d;
    wait_ready(ac);
    if (push) exp_q.push_back(e);
    @(negedge clk);
    req_valid = 0; req_rw = ~rw; req_addr = ~a; req_wdata = ~d;
  endtask

  task automatic wait_rsp(input int n);
    int t = 0;
    while (rsp_cnt < n && t < 400) begin @(negedge clk); t++; end
    repeat (CS_GAP + 2) @(negedge clk);
    check("rsp_count", 32'(rsp_cnt), 32'(n));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int a1, a2, t;
    #2 rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_cs",         32'(cs),             32'd0);
    check("rst_spi_clk",    32'(spi_clk),        32'd0);
    check("rst_pico",       32'(pico),           32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),      32'd0);
    check("rst_rsp_rdata",  32'(rsp_rdata),      32'd0);
    check("rst_addr_err",   32'(rsp_addr_err),   32'd0);
    check("rst_verify_err", 32'(rsp_verify_err), 32'd0);
    check("rst_req_ready",  32'(req_ready),      32'd1);

    // write VCO band = 0xFF
    frames.delete();
    issue(1'b1, ADDR_VCO_BAND, 8'hFF, 1, '{rdata: exp_wr(8'hFF), addr_err: 1'b0, verify_err: 1'b0});
    wait_rsp(1);
    check("wr1_frame",   32'(frames[0]),        32'h81FF);
    check("wr1_cs_high", 32'(last_hi),          32'(FRAME));
    check("wr1_vco",     32'(regs[1][5:0]),     32'h3F);

    // write instruction START
    issue(1'b1, ADDR_INST, INST_START, 1, '{rdata: exp_wr(8'h03), addr_err: 1'b0, verify_err: 1'b0});
    wait_rsp(2);
    check("wr_inst_reg", 32'(regs[3]), 32'h03);

    // read back VCO band
    frames.delete();
    issue(1'b0, ADDR_VCO_BAND, 8'h00, 1, '{rdata: 8'hFF, addr_err: 1'b0, verify_err: 1'b0});
    wait_rsp(3);
    check("rd1_frame", 32'(frames[0]), 32'h0100);

    // poci stuck high during command byte
    err_mode = 1;
    issue(1'b0, ADDR_TRIG_MASK, 8'h00, 1, '{rdata: 8'h00, addr_err: 1'b1, verify_err: 1'b0});
    wait_rsp(4);
    err_mode = 0;

    // back-to-back reads with req_valid held high
    @(negedge clk);
    req_valid = 1; req_rw = 0; req_addr = ADDR_VCO_BAND; req_wdata = 8'h00;
    wait_ready(a1);
    exp_q.push_back('{rdata: 8'hFF, addr_err: 1'b0, verify_err: 1'b0});
    @(negedge clk);
    req_addr = ADDR_INST;
    wait_ready(a2);
    exp_q.push_back('{rdata: 8'h03, addr_err: 1'b0, verify_err: 1'b0});
    @(negedge clk);
    req_valid = 0;
    check("b2b_spacing", 32'(a2 - a1), 32'(FRAME + CS_GAP + 1));
    wait_rsp(6);
    check("b2b_cs_gap",  32'(last_lo), 32'(CS_GAP + 1));

    // reset during bit 10 of a write
    issue(1'b1, ADDR_VCO_BAND, 8'hFF, 0, '0);
    t = 0;
    while (bcnt != 10 && t < 200) begin @(negedge clk); t++; end
    check("mid_rst_reached_bit10", 32'(bcnt), 32'd10);
    rst = 1;
    #1;
    check("mid_rst_cs",      32'(cs),      32'd0);
    check("mid_rst_spi_clk", 32'(spi_clk), 32'd0);
    check("mid_rst_pico",    32'(pico),    32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (100) @(negedge clk);
    check("mid_rst_no_rsp", 32'(rsp_cnt), 32'd6);

    // next request completes normally
    frames.delete();
    issue(1'b0, ADDR_VCO_BAND, 8'h00, 1, '{rdata: 8'hFF, addr_err: 1'b0, verify_err: 1'b0});
    wait_rsp(7);
    check("post_rst_frame", 32'(frames[0]), 32'h0100);

`ifdef PSEC6_SPI_CTRL_VERIFY_EN
    corrupt = 1;
    issue(1'b1, ADDR_DISC_POL, 8'h0A, 1, '{rdata: 8'h0B, addr_err: 1'b0, verify_err: 1'b1});
    wait_rsp(8);
    corrupt = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
